ofdm_qam_mapper: RTL

Constellation mapper for the 802.11a transmit chain. Consumes the serial, interleaved coded bit stream one bit per enabled cycle. Groups bits into N_BPSC-bit words (1/2/4/6 for BPSK/QPSK/16-QAM/64-QAM) and emits one Gray-coded, normalized I/Q point per group toward the IFFT/subcarrier-assembly stage. Flags the last of the 48 data subcarriers of each OFDM symbol.

---
 rtl/ofdm_pkg.sv | 63 ++++++
 rtl/qam_level_lut.sv | 63 ++++++
 rtl/ofdm_qam_mapper.sv | 110 +++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared definitions for the 802.11a constellation mapper: mode encoding,
// bits per subcarrier, Gray level tables and the normalized-level constant function.
package ofdm_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_QAM16 = 2'b10,
        MODE_QAM64 = 2'b11
    } mode_e;

    // Gray tables indexed by the field bits with b0 as the MSB of the index.
    localparam int QAM16_LEVEL [4] = '{-3, -1, 3, 1};
    localparam int QAM64_LEVEL [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

    function automatic logic [2:0] n_bpsc(input mode_e m);
        logic [2:0] n;
        case (m)
            MODE_BPSK:  n = 3'd1;
            MODE_QPSK:  n = 3'd2;
            MODE_QAM16: n = 3'd4;
            default:    n = 3'd6;
        endcase
        return n;
    endfunction

    // Square of the K_MOD denominator: K_MOD = 1/sqrt(k_mod_den_sq).
    function automatic longint k_mod_den_sq(input mode_e m);
        longint d;
        case (m)
            MODE_BPSK:  d = 64'd1;
            MODE_QPSK:  d = 64'd2;
            MODE_QAM16: d = 64'd10;
            default:    d = 64'd42;
        endcase
        return d;
    endfunction

    // round(level * K_MOD * 2^(out_w-2)) in pure integer arithmetic:
    // the result x is the largest integer with (2x-1)^2 * d <= 4 * a^2.
    function automatic int norm_level(input mode_e m, input int level, input int out_w);
        longint a;
        longint d;
        longint num;
        longint lo;
        longint hi;
        longint mid;
        a   = longint'((level < 0) ? -level : level) <<< (out_w - 2);
        d   = k_mod_den_sq(m);
        num = 64'd4 * a * a;
        lo  = 64'd0;
        hi  = a;
        while (lo < hi) begin
            mid = (lo + hi + 64'd1) / 64'd2;
            if ((64'd2 * mid - 64'd1) * (64'd2 * mid - 64'd1) * d <= num)
                lo = mid;
            else
                hi = mid - 64'd1;
        end
        return (level < 0) ? -int'(lo) : int'(lo);
    endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Maps a left-aligned 3-bit Gray field plus mode to a signed OUT_W level.
// QAM_NORM_EN selects normalized levels; otherwise raw integer levels are produced.
module qam_level_lut
    import ofdm_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [1:0]       Mode,
    input  logic [2:0]       Field,
    output logic [OUT_W-1:0] Level
);

`ifdef QAM_NORM_EN
    localparam int S_BPSK  = norm_level(MODE_BPSK, 1, OUT_W);
    localparam int S_QPSK  = norm_level(MODE_QPSK, 1, OUT_W);
    localparam int S16_1   = norm_level(MODE_QAM16, 1, OUT_W);
    localparam int S16_3   = norm_level(MODE_QAM16, 3, OUT_W);
    localparam int S64_1   = norm_level(MODE_QAM64, 1, OUT_W);
    localparam int S64_3   = norm_level(MODE_QAM64, 3, OUT_W);
    localparam int S64_5   = norm_level(MODE_QAM64, 5, OUT_W);
    localparam int S64_7   = norm_level(MODE_QAM64, 7, OUT_W);
`else
    localparam int S_BPSK  = 1;
    localparam int S_QPSK  = 1;
    localparam int S16_1   = 1;
    localparam int S16_3   = 3;
    localparam int S64_1   = 1;
    localparam int S64_3   = 3;
    localparam int S64_5   = 5;
    localparam int S64_7   = 7;
`endif

    int lvl;
    int mag;
    int scaled;

    always_comb begin
        lvl    = 0;
        mag    = 0;
        scaled = 0;
        case (mode_e'(Mode))
            MODE_BPSK, MODE_QPSK: lvl = Field[2] ? 1 : -1;
            MODE_QAM16:           lvl = QAM16_LEVEL[Field[2:1]];
            default:              lvl = QAM64_LEVEL[Field];
        endcase
        mag = (lvl < 0) ? -lvl : lvl;
        case (mode_e'(Mode))
            MODE_BPSK:  scaled = S_BPSK;
            MODE_QPSK:  scaled = S_QPSK;
            MODE_QAM16: scaled = (mag == 1) ? S16_1 : S16_3;
            default: begin
                case (mag)
                    1:       scaled = S64_1;
                    3:       scaled = S64_3;
                    5:       scaled = S64_5;
                    default: scaled = S64_7;
                endcase
            end
        endcase
        Level = (lvl < 0) ? OUT_W'(-scaled) : OUT_W'(scaled);
    end

endmodule

// File: rtl/ofdm_qam_mapper.sv
// 802.11a constellation mapper: groups serial coded bits into N_BPSC words and emits
// one Gray-coded I/Q point per group; QAM_NORM_EN selects normalized vs raw levels.
module ofdm_qam_mapper
    import ofdm_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int N_SD  = 48
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Data,
    input  logic [1:0]       Mode,
    output logic [OUT_W-1:0] Out_I,
    output logic [OUT_W-1:0] Out_Q,
    output logic             Out_valid,
    output logic             Sym_last
);

    localparam int SC_W = (N_SD > 1) ? $clog2(N_SD) : 1;

    // Only the five previously accepted bits are kept; the sixth is Data itself.
    logic [4:0]      grp_sr;
    logic [2:0]      bit_cnt;
    mode_e           mode_q;
    logic [SC_W-1:0] sc_cnt;

    mode_e           eff_mode;
    logic [5:0]      word;
    logic            grp_done;
    logic [2:0]      field_i;
    logic [2:0]      field_q;
    logic [OUT_W-1:0] lut_i;
    logic [OUT_W-1:0] lut_q;

    assign word     = {grp_sr, Data};
    assign eff_mode = (bit_cnt == 3'd0) ? mode_e'(Mode) : mode_q;
    assign grp_done = (bit_cnt == (n_bpsc(eff_mode) - 3'd1));

    // b0 sits at the MSB of the completed word; fields are left-aligned for the LUT.
    always_comb begin
        field_i = 3'b000;
        field_q = 3'b000;
        case (eff_mode)
            MODE_BPSK: begin
                field_i = {word[0], 2'b00};
            end
            MODE_QPSK: begin
                field_i = {word[1], 2'b00};
                field_q = {word[0], 2'b00};
            end
            MODE_QAM16: begin
                field_i = {word[3:2], 1'b0};
                field_q = {word[1:0], 1'b0};
            end
            default: begin
                field_i = word[5:3];
                field_q = word[2:0];
            end
        endcase
    end

    qam_level_lut #(.OUT_W(OUT_W)) u_lut_i (
        .Mode  (eff_mode),
        .Field (field_i),
        .Level (lut_i)
    );

    qam_level_lut #(.OUT_W(OUT_W)) u_lut_q (
        .Mode  (eff_mode),
        .Field (field_q),
        .Level (lut_q)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            grp_sr    <= '0;
            bit_cnt   <= 3'd0;
            mode_q    <= MODE_BPSK;
            sc_cnt    <= '0;
            Out_I     <= '0;
            Out_Q     <= '0;
            Out_valid <= 1'b0;
            Sym_last  <= 1'b0;
        end else begin
            Out_valid <= 1'b0;
            Sym_last  <= 1'b0;
            if (En) begin
                grp_sr <= word[4:0];
                if (bit_cnt == 3'd0)
                    mode_q <= mode_e'(Mode);
                if (grp_done) begin
                    bit_cnt   <= 3'd0;
                    Out_valid <= 1'b1;
                    Out_I     <= lut_i;
                    Out_Q     <= (eff_mode == MODE_BPSK) ? '0 : lut_q;
                    if (sc_cnt == SC_W'(N_SD - 1)) begin
                        sc_cnt   <= '0;
                        Sym_last <= 1'b1;
                    end else begin
                        sc_cnt <= sc_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule
